// File: rtl/sync_fifo_param_pkg.sv
`default_nettype none
//==============================================================================
// sync_fifo_param_pkg : shared types, width helpers and defaults for the FIFO.
// Rev 1.0
//==============================================================================
package sync_fifo_param_pkg;

    localparam int DEFAULT_DATA_W = 8;

    typedef logic push_t;
    typedef logic pop_t;

    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
        logic overflow;
        logic underflow;
    } fifo_status_t;

    function automatic int addr_w(input int depth);
        return $clog2(depth);
    endfunction

    // One extra bit so the count can represent DEPTH itself.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo_param_if.sv
`default_nettype none
//==============================================================================
// sync_fifo_param_if : push/pop handshake, data and status bundle of the FIFO.
// Rev 1.0
//==============================================================================
interface sync_fifo_param_if
    import sync_fifo_param_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int DEPTH  = 16
);
    localparam int CNT_W = cnt_w(DEPTH);

    logic              push;
    logic              pop;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] data_out;
    logic              rd_valid;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic              almost_empty;
    logic [CNT_W-1:0]  count;
    logic              overflow;
    logic              underflow;

    modport master (
        output push, pop, data_in,
        input  data_out, rd_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  push, pop, data_in,
        output data_out, rd_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

endinterface
`default_nettype wire

// File: rtl/sync_fifo_param_mem.sv
`default_nettype none
//==============================================================================
// sync_fifo_param_mem : simple dual-port storage array; registered read port,
//   asynchronous read when SYNC_FIFO_FWFT_EN is defined. Rev 1.0
//==============================================================================
module sync_fifo_param_mem #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    assign rdata = mem_q[raddr];
`else
    // Read-before-write: a same-address push returns the old word.
    always_ff @(posedge clk) begin
        rdata <= mem_q[raddr];
    end
`endif

endmodule
`default_nettype wire

// File: rtl/sync_fifo_param.sv
`default_nettype none
//==============================================================================
// sync_fifo_param : single-clock FIFO with count, thresholds, sticky errors.
//   SYNC_FIFO_FWFT_EN selects first-word fall-through reads. Rev 1.0
//==============================================================================
module sync_fifo_param
    import sync_fifo_param_pkg::*;
#(
    parameter int DATA_W    = DEFAULT_DATA_W,
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 2
) (
    input  logic             clk,
    input  logic             rst,
    sync_fifo_param_if.slave bus
);
    localparam int                 c_addr_w   = addr_w(DEPTH);
    localparam int                 c_cnt_w    = cnt_w(DEPTH);
    localparam logic [c_cnt_w-1:0] c_full_cnt = c_cnt_w'(DEPTH);
    localparam logic [c_cnt_w-1:0] c_af_cnt   = c_cnt_w'(AF_THRESH);
    localparam logic [c_cnt_w-1:0] c_ae_cnt   = c_cnt_w'(AE_THRESH);
    localparam logic               c_af_rst   = (AF_THRESH == 0);

    push_t               w_push_ok;
    pop_t                w_pop_ok;
    logic [c_addr_w-1:0] wr_ptr_q, wr_ptr_d;
    logic [c_addr_w-1:0] rd_ptr_q, rd_ptr_d;
    logic [c_cnt_w-1:0]  count_q, count_d;
    logic                full_q, full_d;
    logic                empty_q, empty_d;
    logic                af_q, af_d;
    logic                ae_q, ae_d;
    logic                overflow_q, overflow_d;
    logic                underflow_q, underflow_d;
    logic [DATA_W-1:0]   w_rdata;

    always_comb begin
        w_pop_ok  = bus.pop && !empty_q;
        // A pop in the same cycle frees a slot, so a push into a full FIFO is legal then.
        w_push_ok = bus.push && (!full_q || w_pop_ok);

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (w_push_ok) wr_ptr_d = wr_ptr_q + c_addr_w'(1);
        if (w_pop_ok)  rd_ptr_d = rd_ptr_q + c_addr_w'(1);

        case ({w_push_ok, w_pop_ok})
            2'b10:   count_d = count_q + c_cnt_w'(1);
            2'b01:   count_d = count_q - c_cnt_w'(1);
            default: count_d = count_q;
        endcase

        full_d      = (count_d == c_full_cnt);
        empty_d     = (count_d == '0);
        af_d        = (count_d >= c_af_cnt);
        ae_d        = (count_d <= c_ae_cnt);
        overflow_d  = overflow_q  || (bus.push && full_q && !w_pop_ok);
        underflow_d = underflow_q || (bus.pop && empty_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            af_q        <= c_af_rst;
            ae_q        <= 1'b1;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            full_q      <= full_d;
            empty_q     <= empty_d;
            af_q        <= af_d;
            ae_q        <= ae_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    sync_fifo_param_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (c_addr_w)
    ) u_mem (
        .clk   (clk),
        .we    (w_push_ok),
        .waddr (wr_ptr_q),
        .wdata (bus.data_in),
        .raddr (rd_ptr_q),
        .rdata (w_rdata)
    );

`ifdef SYNC_FIFO_FWFT_EN
    assign bus.rd_valid = ~empty_q;
    assign bus.data_out = w_rdata;
`else
    logic              rd_valid_q, rd_valid_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;

    // The array re-reads every cycle, so the shown word is latched once its valid cycle ends.
    always_comb begin
        rd_valid_d = w_pop_ok;
        data_out_d = rd_valid_q ? w_rdata : data_out_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid_q <= 1'b0;
            data_out_q <= '0;
        end else begin
            rd_valid_q <= rd_valid_d;
            data_out_q <= data_out_d;
        end
    end

    assign bus.rd_valid = rd_valid_q;
    assign bus.data_out = data_out_d;
`endif

    assign bus.count        = count_q;
    assign bus.full         = full_q;
    assign bus.empty        = empty_q;
    assign bus.almost_full  = af_q;
    assign bus.almost_empty = ae_q;
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_param.sv
`default_nettype none
//==============================================================================
// tb_sync_fifo_param : directed self-checking bench for sync_fifo_param
//   (DEPTH=16, AF=14, AE=2), both read modes via SYNC_FIFO_FWFT_EN. Rev 1.0
//==============================================================================
module tb_sync_fifo_param;
    import sync_fifo_param_pkg::*;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;
    localparam int AF     = 14;
    localparam int AE     = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad   = 0;

    sync_fifo_param_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

    sync_fifo_param #(
        .DATA_W    (DATA_W),
        .DEPTH     (DEPTH),
        .AF_THRESH (AF),
        .AE_THRESH (AE)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic fifo_status_t status();
        return {bus.full, bus.empty, bus.almost_full, bus.almost_empty,
                bus.overflow, bus.underflow};
    endfunction

    task automatic do_reset();
        rst = 1'b1; bus.push = 1'b0; bus.pop = 1'b0; bus.data_in = '0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (bus.count !== 5'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", bus.count); end
        total++; if (status() !== 6'b010100) begin bad++; $display("FAIL reset_status: got %b want 010100", status()); end
        total++; if (bus.rd_valid !== 1'b0) begin bad++; $display("FAIL reset_rd_valid: got %b want 0", bus.rd_valid); end
`ifndef SYNC_FIFO_FWFT_EN
        total++; if (bus.data_out !== 8'h00) begin bad++; $display("FAIL reset_data_out: got %h want 00", bus.data_out); end
`endif
    endtask

    task automatic test_fill();
        for (int i = 0; i < DEPTH; i++) begin
            bus.push = 1'b1; bus.data_in = 8'(i);
            tick();
            total++; if (bus.count !== 5'(i + 1)) begin bad++; $display("FAIL fill_count[%0d]: got %0d want %0d", i, bus.count, i + 1); end
            total++; if (bus.almost_full !== 1'((i + 1) >= AF)) begin bad++; $display("FAIL fill_af[%0d]: got %b want %b", i, bus.almost_full, (i + 1) >= AF); end
            total++; if (bus.almost_empty !== 1'((i + 1) <= AE)) begin bad++; $display("FAIL fill_ae[%0d]: got %b want %b", i, bus.almost_empty, (i + 1) <= AE); end
        end
        total++; if (bus.full !== 1'b1) begin bad++; $display("FAIL fill_full: got %b want 1", bus.full); end
        bus.data_in = 8'hAA;
        tick();
        bus.push = 1'b0;
        total++; if (bus.count !== 5'd16) begin bad++; $display("FAIL overflow_count: got %0d want 16", bus.count); end
        total++; if (status() !== 6'b101010) begin bad++; $display("FAIL overflow_status: got %b want 101010", status()); end
    endtask

    task automatic test_drain();
        for (int j = 0; j < DEPTH; j++) begin
`ifdef SYNC_FIFO_FWFT_EN
            total++; if (bus.rd_valid !== 1'b1 || bus.data_out !== 8'(j)) begin bad++; $display("FAIL drain_data[%0d]: got v=%b %h want v=1 %h", j, bus.rd_valid, bus.data_out, 8'(j)); end
`endif
            bus.pop = 1'b1;
            tick();
`ifndef SYNC_FIFO_FWFT_EN
            total++; if (bus.rd_valid !== 1'b1 || bus.data_out !== 8'(j)) begin bad++; $display("FAIL drain_data[%0d]: got v=%b %h want v=1 %h", j, bus.rd_valid, bus.data_out, 8'(j)); end
`endif
            total++; if (bus.count !== 5'(15 - j)) begin bad++; $display("FAIL drain_count[%0d]: got %0d want %0d", j, bus.count, 15 - j); end
            total++; if (bus.almost_empty !== 1'((15 - j) <= AE)) begin bad++; $display("FAIL drain_ae[%0d]: got %b want %b", j, bus.almost_empty, (15 - j) <= AE); end
        end
        total++; if (status() !== 6'b010110) begin bad++; $display("FAIL drain_status: got %b want 010110", status()); end
        tick();
        bus.pop = 1'b0;
        total++; if (status() !== 6'b010111) begin bad++; $display("FAIL underflow_status: got %b want 010111", status()); end
        total++; if (bus.rd_valid !== 1'b0) begin bad++; $display("FAIL underflow_rd_valid: got %b want 0", bus.rd_valid); end
        total++; if (bus.count !== 5'd0) begin bad++; $display("FAIL underflow_count: got %0d want 0", bus.count); end
`ifndef SYNC_FIFO_FWFT_EN
        total++; if (bus.data_out !== 8'h0F) begin bad++; $display("FAIL hold_data_out: got %h want 0f", bus.data_out); end
`endif
    endtask

    // Pops one word with the mode-appropriate latency and checks it.
    task automatic pop_check(input string name, input logic [7:0] want);
        bus.pop = 1'b1;
`ifdef SYNC_FIFO_FWFT_EN
        total++; if (bus.data_out !== want) begin bad++; $display("FAIL %s: got %h want %h", name, bus.data_out, want); end
        tick();
`else
        tick();
        total++; if (bus.data_out !== want) begin bad++; $display("FAIL %s: got %h want %h", name, bus.data_out, want); end
`endif
    endtask

    task automatic test_wrap();
        int exp_w = 0;
        for (int i = 0; i < 5; i++) begin
            bus.push = 1'b1; bus.data_in = 8'(i);
            tick();
        end
        for (int i = 5; i < 40; i++) begin
            bus.push = 1'b1; bus.data_in = 8'(i);
            pop_check("wrap_data", 8'(exp_w));
            exp_w++;
            total++; if (bus.count !== 5'd5) begin bad++; $display("FAIL wrap_count[%0d]: got %0d want 5", i, bus.count); end
        end
        bus.push = 1'b0;
        for (int i = 0; i < 5; i++) begin
            pop_check("wrap_tail", 8'(exp_w));
            exp_w++;
        end
        bus.pop = 1'b0;
        total++; if (bus.empty !== 1'b1) begin bad++; $display("FAIL wrap_empty: got %b want 1", bus.empty); end
    endtask

    task automatic test_full_pushpop();
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            bus.push = 1'b1; bus.data_in = 8'(8'h80 + i);
            tick();
        end
        bus.data_in = 8'h90;
        pop_check("fullpp_oldest", 8'h80);
        bus.push = 1'b0; bus.pop = 1'b0;
        total++; if (bus.count !== 5'd16) begin bad++; $display("FAIL fullpp_count: got %0d want 16", bus.count); end
        total++; if (status() !== 6'b101000) begin bad++; $display("FAIL fullpp_status: got %b want 101000", status()); end
        for (int j = 0; j < DEPTH; j++) begin
            pop_check("fullpp_drain", 8'(8'h81 + j));
        end
        bus.pop = 1'b0;
        total++; if (bus.empty !== 1'b1) begin bad++; $display("FAIL fullpp_empty: got %b want 1", bus.empty); end
    endtask

    task automatic test_empty_pushpop();
        bus.push = 1'b1; bus.pop = 1'b1; bus.data_in = 8'h5A;
        tick();
        bus.push = 1'b0; bus.pop = 1'b0;
        total++; if (bus.count !== 5'd1) begin bad++; $display("FAIL emptypp_count: got %0d want 1", bus.count); end
        total++; if (status() !== 6'b000101) begin bad++; $display("FAIL emptypp_status: got %b want 000101", status()); end
`ifdef SYNC_FIFO_FWFT_EN
        total++; if (bus.rd_valid !== 1'b1) begin bad++; $display("FAIL emptypp_rd_valid: got %b want 1", bus.rd_valid); end
`else
        total++; if (bus.rd_valid !== 1'b0) begin bad++; $display("FAIL emptypp_rd_valid: got %b want 0", bus.rd_valid); end
`endif
        pop_check("emptypp_data", 8'h5A);
        bus.pop = 1'b0;
        total++; if (bus.count !== 5'd0) begin bad++; $display("FAIL emptypp_count2: got %0d want 0", bus.count); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < DEPTH + 1; i++) begin
            bus.push = 1'b1; bus.data_in = 8'(8'h10 + i);
            tick();
        end
        bus.push = 1'b0;
        for (int i = 0; i < 7; i++) begin
            bus.pop = 1'b1;
            tick();
        end
        bus.pop = 1'b0;
        total++; if (bus.count !== 5'd9 || bus.overflow !== 1'b1) begin bad++; $display("FAIL midrst_pre: got cnt=%0d ovf=%b want cnt=9 ovf=1", bus.count, bus.overflow); end
        do_reset();
        total++; if (bus.count !== 5'd0) begin bad++; $display("FAIL midrst_count: got %0d want 0", bus.count); end
        total++; if (status() !== 6'b010100) begin bad++; $display("FAIL midrst_status: got %b want 010100", status()); end
        total++; if (bus.rd_valid !== 1'b0) begin bad++; $display("FAIL midrst_rd_valid: got %b want 0", bus.rd_valid); end
`ifndef SYNC_FIFO_FWFT_EN
        total++; if (bus.data_out !== 8'h00) begin bad++; $display("FAIL midrst_data_out: got %h want 00", bus.data_out); end
`endif
        bus.push = 1'b1; bus.data_in = 8'h33;
        tick();
        bus.push = 1'b0;
        pop_check("midrst_data", 8'h33);
        bus.pop = 1'b0;
    endtask

    initial begin
        bus.push = 1'b0; bus.pop = 1'b0; bus.data_in = '0;
        test_reset();
        test_fill();
        test_drain();
        test_wrap();
        test_full_pushpop();
        test_empty_pushpop();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
- Single-clock, parametrised successor to the existing push/pop FIFO.
- Generic DATA_W/DEPTH replaces the fixed valores_t width.
- Adds an occupancy count, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags and a read-valid strobe.
- Sits between producer and consumer blocks in the same clock domain; the existing FIFO interface push/pop/data_in/data_out/full/empty semantics are kept.

Parameters:
- DATA_W, 8, data word width in bits.
- DEPTH, 16, number of entries; power of two, minimum 2.
- AF_THRESH, DEPTH-2, almost_full asserts when count >= AF_THRESH.
- AE_THRESH, 2, almost_empty asserts when count <= AE_THRESH.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- push  input  1  write request.
- pop  input  1  read request.
- data_in  input  DATA_W  write data.
- data_out  output  DATA_W  read data.
- rd_valid  output  1  data_out holds a freshly popped word.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- almost_full  output  1  count >= AF_THRESH.
- almost_empty  output  1  count <= AE_THRESH.
- count  output  $clog2(DEPTH)+1  current occupancy.
- overflow  output  1  sticky: a push was attempted while full without a pop.
- underflow  output  1  sticky: a pop was attempted while empty.

Behaviour:
- Reset:
  - Sampled only on the rising clk edge while rst=1.
  - wr_ptr=rd_ptr=0, count=0, empty=1, full=0, almost_empty=1.
  - almost_full=(AF_THRESH==0), data_out=0, rd_valid=0, overflow=0, underflow=0.
  - Memory contents are not cleared.
  - A reset mid-operation discards all stored words; the next cycle behaves as after power-on reset.
- Pointers and count:
  - Pointers are $clog2(DEPTH) bits and wrap from DEPTH-1 to 0 naturally.
  - count is tracked in a separate register of $clog2(DEPTH)+1 bits.
  - Flags are registered, derived from the next-state count, so they are valid in the same cycle as the new count.
- Write: push=1 and (full=0 or pop accepted) -> mem[wr_ptr]<=data_in, wr_ptr+1.
- Read (default, registered output):
  - pop=1 and empty=0 -> data_out<=mem[rd_ptr], rd_ptr+1, rd_valid=1 in the next cycle.
  - Latency from pop to data is 1 clk.
  - rd_valid=0 on any cycle with no accepted pop; data_out holds its last value.
- Simultaneous events:
  - push+pop, 0<count<DEPTH: both accepted, count unchanged.
  - push+pop while full: both accepted; no overflow; count stays DEPTH.
  - push+pop while empty: push accepted, pop rejected; underflow set; count -> 1.
  - push while full without pop: ignored; memory and wr_ptr unchanged; overflow<=1.
  - pop while empty: ignored; underflow<=1; rd_valid=0.
- overflow and underflow are cleared only by rst.
- No internal state machine beyond the pointer/count datapath. The two modes (registered vs FWFT) are fixed at compile time.

Optional Feature:
- Macro: SYNC_FIFO_FWFT_EN.
- Defined (first-word fall-through):
  - data_out = mem[rd_ptr] combinationally whenever empty=0.
  - rd_valid = ~empty.
  - pop acknowledges the shown word and advances rd_ptr; next word visible in the following cycle.
  - Pop-to-data latency is 0.
  - data_out is don't-care while empty.
- Undefined: the registered 1-cycle read described above.
- Flag, count and error behaviour are identical in both modes.

Decomposition:
- fifo_pkg gains the following:
  - parametrised-width helpers: function clog2-based ADDR_W/CNT_W computation.
  - push_t/pop_t (1-bit logic).
  - a default DATA_W constant matching valores_t.
  - fifo_status_t, a packed struct {full, empty, almost_full, almost_empty, overflow, underflow}, for bench monitors.
- Sub-module: fifo_mem, a simple dual-port array.
  - Ports: clk, we, waddr, wdata, raddr, rdata.
  - rdata is registered, or asynchronous when SYNC_FIFO_FWFT_EN is defined.
- The pointer, count and flag logic stays in sync_fifo_param.

Test Plan:
1. Reset, then 16 pushes of 0x00..0x0F (DEPTH=16):
   - count=16, full=1.
   - almost_full rises at count=14.
   - A 17th push of 0xAA -> ignored, overflow=1.
2. From full, 16 pops:
   - data_out sequence 0x00..0x0F, each 1 clk after its pop (0 clk with FWFT).
   - empty=1 after the last pop; almost_empty rises at count=2.
   - A further pop -> underflow=1, rd_valid=0.
3. Wrap-around: push/pop interleaved for 40 words 0x00..0x27 at count~5:
   - Output order is preserved across pointer wrap.
   - count is steady at 5.
4. Simultaneous push+pop while full (count=16): count stays 16, no overflow, popped word = oldest, pushed word appears last.
5. Simultaneous push 0x5A + pop while empty: count=1, underflow=1; next pop returns 0x5A.
6. Assert rst with count=9 and overflow=1: next cycle count=0, empty=1, overflow=0, data_out=0; subsequent push 0x33 then pop returns 0x33.
